trig_delay_gen: RTL and testbench
=================================

# trig_delay_gen

Four-channel programmable delayed-pulse generator. It sits directly downstream of the UART receive/command stage. That stage decodes `S` + `0`..`3` + value byte sequences into four 8-bit channel values and raises `busy` once a received burst is complete. This block commits those values on `busy` rising, and on each external trigger edge it emits one pulse per enabled channel after that channel's programmed delay.

## Interface
Parameters:
- `TICK_DIV`, default 1250: clk cycles per delay tick (2..2^20). 1250 equals one 9600-baud bit period at the system clock.
- `PULSE_W`, default 8: output pulse width in ticks (1..255).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `busy`  in  1  UART stage busy flag, synchronous to `clk`. Its rising edge commits the configuration.
- `trig_val_ch0`..`trig_val_ch3`  in  8 each  channel delay values from the UART stage. These bits shift while a byte is being received, so they are only valid when `busy` rises.
- `ext_trig`  in  1  asynchronous external trigger; fires on a rising edge.
- `trig_out`  out  4  per-channel pulse outputs.
- `run`  out  1  high while any channel is not IDLE.
- `done`  out  1  one-cycle strobe when a fire sequence completes.
- `cfg_upd`  out  1  one-cycle strobe when the configuration is committed.

## Operation
- Config shadow `dly[0..3]` (8 b each):
  - Loaded from `trig_val_ch*` in the cycle after `busy` is sampled 0 then 1.
  - `cfg_upd` pulses in that same cycle.
  - A load is allowed at any time, including while `run` is high.
- Trigger synchronizer:
  - 2-flop synchronizer, then a rising-edge detect that produces `fire`.
  - `fire` is accepted only when `run`=0. An edge arriving while `run`=1 is dropped, not queued.
- Prescaler:
  - Counter 0..`TICK_DIV`-1; `tick` is high when the counter equals `TICK_DIV`-1.
  - Cleared to 0 on an accepted `fire`, so delays are exact with no jitter.
- Channel FSM (one instance per channel), states IDLE, DELAY, PULSE:
  - IDLE→DELAY on accepted `fire` if `dly[n]`≠0: `cnt`←`dly[n]`. Channels with `dly[n]`=0 stay IDLE.
  - In DELAY, on `tick`: if `cnt`=1 go to PULSE with `cnt`←`PULSE_W`; otherwise `cnt`−1.
  - In PULSE, on `tick`: if `cnt`=1 go to IDLE; otherwise `cnt`−1.
  - `trig_out[n]` is registered: high exactly while in PULSE.
  - The delay is captured at fire, so a later config load does not affect channels already in flight.
- `run` = OR of (state≠IDLE) across channels.
- `done` pulses for one cycle on the cycle `run` falls 1→0.
  - An accepted `fire` with every `dly`=0 leaves `run` at 0 and produces no `done`.
- `cnt` is 8 bits with no wrap: the value 255 yields 255 ticks.

## Timing
- Reset values: `trig_out`=0, `run`=0, `done`=0, `cfg_upd`=0, all `dly`=0, all FSMs IDLE, prescaler=0, synchronizer flops=0.
- Reset mid-operation aborts immediately; outputs drop asynchronously.
- Trigger latency: `ext_trig` is sampled high at edge E; `fire` is registered at edge E+2 (call it F).
  - `trig_out[n]` rises at F + `dly[n]`·`TICK_DIV`.
  - It stays high for `PULSE_W`·`TICK_DIV` cycles.
  - `run` rises at F+1. `done` is high in the cycle after the last channel leaves PULSE.
- `busy` rising edge: `cfg_upd` and the new `dly` are visible 1 cycle after the edge where `busy`=1 is first sampled.
- Simultaneous `busy` rise and accepted `fire` in the same cycle: `fire` uses the old `dly`.

## Structure
- Package `trig_pkg`: channel state enum (IDLE/DELAY/PULSE), `NCH`=4, the default `TICK_DIV`/`PULSE_W` constants.
- Sub-module `trig_chan`: one channel FSM plus its `cnt`, instantiated four times. The top level holds the synchronizer, prescaler, config shadow and the `run`/`done` logic.

## Test plan
All scenarios use `TICK_DIV`=4, `PULSE_W`=2.
- Reset, all `dly`=0, pulse `ext_trig` -> `trig_out`=0, `run`=0, no `done`, no `cfg_upd`.
- `trig_val_ch0`=3, `trig_val_ch2`=1, `busy` 0→1:
  - `cfg_upd` high for 1 cycle.
  - Then `ext_trig` with fire at F -> `trig_out[2]` high F+4..F+11, `trig_out[0]` high F+12..F+19.
  - `done` pulses at F+20; ch1 and ch3 stay 0.
- With the same config, a second `ext_trig` edge at F+6 -> ignored: exactly one pulse per channel, single `done`.
- Load `ch0`=5 via `busy` rise at F+2 during a run with `ch0`=3:
  - The current pulse still rises at F+12.
  - The next fire F' gives a rise at F'+20.
- `ch3`=255, fire -> `trig_out[3]` rises at F+1020, width 8 cycles.
- Assert `rst` while `trig_out[0]`=1 -> all outputs 0 at once; no `done`; the next fire behaves as from reset with `dly`=0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared types and defaults for the four-channel delayed-pulse generator.
package trig_pkg;

    localparam int NCH          = 4;
    localparam int DEF_TICK_DIV = 1250;
    localparam int DEF_PULSE_W  = 8;

    typedef logic [7:0] dly_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } chan_state_t;

endpackage

// File: rtl/trig_chan.sv
// One delay/pulse channel: counts dly ticks after fire, then holds its output for PULSE_W ticks.
module trig_chan
    import trig_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic tick,
    input  dly_t dly,
    output logic active,
    output logic pulse
);

    chan_state_t state, state_nxt;
    dly_t        cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Registered from next state so the output tracks PULSE with no extra cycle of lag.
            pulse <= (state_nxt == PULSE);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (fire && dly != '0) begin
                    state_nxt = DELAY;
                    cnt_nxt   = dly;
                end
            end
            DELAY: begin
                if (tick) begin
                    if (cnt == 8'd1) begin
                        state_nxt = PULSE;
                        cnt_nxt   = 8'(PULSE_W);
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            PULSE: begin
                if (tick) begin
                    if (cnt == 8'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        active = (state != IDLE);
    end

endmodule

// File: rtl/trig_delay_gen.sv
// Four-channel programmable delayed-pulse generator: config shadow committed on busy rise,
// trigger synchronizer, jitter-free tick prescaler and run/done tracking around four channels.
module trig_delay_gen
    import trig_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PULSE_W  = DEF_PULSE_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic [7:0] trig_val_ch0,
    input  logic [7:0] trig_val_ch1,
    input  logic [7:0] trig_val_ch2,
    input  logic [7:0] trig_val_ch3,
    input  logic       ext_trig,
    output logic [3:0] trig_out,
    output logic       run,
    output logic       done,
    output logic       cfg_upd
);

    localparam int                PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [2:0]       sync_q;
    logic             fire_edge;
    logic             fire_ok;
    logic             fire_q;
    logic [PRE_W-1:0] presc_q;
    logic             tick;
    logic             busy_q, busy_qq;
    dly_t             val_in  [NCH];
    dly_t             stage_q [NCH];
    dly_t             dly_q   [NCH];
    logic [NCH-1:0]   ch_active;
    logic             run_q;

    always_comb begin
        val_in[0] = trig_val_ch0;
        val_in[1] = trig_val_ch1;
        val_in[2] = trig_val_ch2;
        val_in[3] = trig_val_ch3;
    end

    // Two synchronizer flops plus one history flop for the rising-edge detect.
    assign fire_edge = sync_q[1] & ~sync_q[2];
    assign fire_ok   = fire_edge & ~run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fire_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            sync_q <= {sync_q[1:0], ext_trig};
            fire_q <= fire_ok;
        end
    end

    // Cleared together with the accepted fire, so the first tick lands exactly TICK_DIV cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (fire_ok || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    assign tick = (presc_q == PRE_MAX);

    // Values are snapshotted on the busy edge itself, since they keep shifting afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            busy_qq <= 1'b0;
            cfg_upd <= 1'b0;
            // NOTE: small flop arrays, not RAM; they must read zero after reset, so each is cleared.
            for (int n = 0; n < NCH; n++) begin
                stage_q[n] <= '0;
                dly_q[n]   <= '0;
            end
        end else begin
            busy_q  <= busy;
            busy_qq <= busy_q;
            cfg_upd <= busy_q & ~busy_qq;
            if (busy && !busy_q) begin
                stage_q <= val_in;
            end
            if (busy_q && !busy_qq) begin
                dly_q <= stage_q;
            end
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        trig_chan #(
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .fire   (fire_q),
            .tick   (tick),
            .dly    (dly_q[n]),
            .active (ch_active[n]),
            .pulse  (trig_out[n])
        );
    end

    assign run = |ch_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run;
        end
    end

    assign done = run_q & ~run;

endmodule

// File: tb/tb_trig_delay_gen.sv
// Self-checking bench for trig_delay_gen: directed scenarios plus random triggers/config loads
// compared every cycle against a timeline model built from delay arithmetic.
module tb_trig_delay_gen;

    localparam int TD = 4;
    localparam int PW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy = 1'b0;
    logic       ext_trig = 1'b0;
    logic [7:0] tv0 = '0, tv1 = '0, tv2 = '0, tv3 = '0;
    logic [3:0] trig_out;
    logic       run, done, cfg_upd;

    trig_delay_gen #(
        .TICK_DIV (TD),
        .PULSE_W  (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .busy         (busy),
        .trig_val_ch0 (tv0),
        .trig_val_ch1 (tv1),
        .trig_val_ch2 (tv2),
        .trig_val_ch3 (tv3),
        .ext_trig     (ext_trig),
        .trig_out     (trig_out),
        .run          (run),
        .done         (done),
        .cfg_upd      (cfg_upd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timeline model: committed delays, and for the current fire each channel's
    // [rise, fall) window plus the [start, end) window of run.
    int m_dly  [4];
    int m_rise [4];
    int m_fall [4];
    int m_run_s, m_run_e;
    int pend_cyc;
    int pend_val [4];
    int fq [$];
    bit chk_en = 1'b0;

    function automatic void model_clear();
        for (int n = 0; n < 4; n++) begin
            m_dly[n]  = 0;
            m_rise[n] = -1;
            m_fall[n] = -1;
        end
        m_run_s  = -1;
        m_run_e  = -1;
        pend_cyc = -1;
        fq.delete();
    endfunction

    function automatic void model_fire(input int f);
        int last;
        bool_any: begin end
        if (m_run_s <= f - 1 && f - 1 < m_run_e) return;
        last = -1;
        for (int n = 0; n < 4; n++) begin
            if (m_dly[n] != 0) begin
                m_rise[n] = f + m_dly[n] * TD;
                m_fall[n] = m_rise[n] + PW * TD;
                if (m_fall[n] > last) last = m_fall[n];
            end else begin
                m_rise[n] = -1;
                m_fall[n] = -1;
            end
        end
        if (last >= 0) begin
            m_run_s = f + 1;
            m_run_e = last;
        end
    endfunction

    int rise_obs [4];
    int fall_obs [4];
    int rise_cnt [4];
    int done_cnt, done_at, cfg_cnt;
    logic [3:0] prev_to = '0;

    task automatic clear_obs();
        for (int n = 0; n < 4; n++) begin
            rise_obs[n] = -1;
            fall_obs[n] = -1;
            rise_cnt[n] = 0;
        end
        done_cnt = 0;
        done_at  = -1;
        cfg_cnt  = 0;
    endtask

    always @(negedge clk) begin : mon
        int t;
        int f;
        logic [3:0] et;
        t = cyc;
        for (int n = 0; n < 4; n++) begin
            if (trig_out[n] && !prev_to[n]) begin
                rise_obs[n] = t;
                rise_cnt[n]++;
            end
            if (!trig_out[n] && prev_to[n]) fall_obs[n] = t;
        end
        prev_to = trig_out;
        if (done) begin
            done_cnt++;
            done_at = t;
        end
        if (cfg_upd) cfg_cnt++;

        if (!rst && chk_en) begin
            if (t == pend_cyc) begin
                for (int n = 0; n < 4; n++) m_dly[n] = pend_val[n];
            end
            while (fq.size() > 0 && fq[0] <= t) begin
                f = fq.pop_front();
                if (f == t) model_fire(f);
            end
            for (int n = 0; n < 4; n++)
                et[n] = (m_rise[n] >= 0) && (t >= m_rise[n]) && (t < m_fall[n]);
            check($sformatf("out@%0d", t), {25'd0, trig_out, run, done, cfg_upd},
                  {25'd0, et, (t >= m_run_s && t < m_run_e), (t == m_run_e), (t == pend_cyc)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    // Edge sampled at the next clock; fire registers two clocks after that.
    task automatic pulse_trig(input int h, output int f);
        step();
        ext_trig = 1'b1;
        f = cyc + 3;
        fq.push_back(f);
        idle(h);
        ext_trig = 1'b0;
        idle(2);
    endtask

    task automatic load_cfg(input int v0, input int v1, input int v2, input int v3);
        step();
        tv0 = v0[7:0];
        tv1 = v1[7:0];
        tv2 = v2[7:0];
        tv3 = v3[7:0];
        busy = 1'b1;
        pend_cyc = cyc + 2;
        pend_val[0] = v0;
        pend_val[1] = v1;
        pend_val[2] = v2;
        pend_val[3] = v3;
        step();
        tv0 = 8'($urandom);
        tv1 = 8'($urandom);
        tv2 = 8'($urandom);
        tv3 = 8'($urandom);
        idle(2);
        busy = 1'b0;
        idle(2);
    endtask

    function automatic int rand_dly();
        if ($urandom_range(0, 3) == 0) return 0;
        return $urandom_range(1, 12);
    endfunction

    int f, f2;

    initial begin
        rst = 1'b1;
        model_clear();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'd0, trig_out, run, done, cfg_upd}, 32'd0);
        idle(1);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // All delays zero: fire produces nothing.
        clear_obs();
        pulse_trig(2, f);
        wait_to(f + 20);
        check("zero_done", done_cnt, 0);
        check("zero_cfg", cfg_cnt, 0);
        check("zero_rises", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);

        // ch0=3, ch2=1.
        clear_obs();
        load_cfg(3, 0, 1, 0);
        check("cfg_upd_once", cfg_cnt, 1);
        clear_obs();
        pulse_trig(2, f);
        wait_to(f + 24);
        check("ch2_rise", rise_obs[2], f + 4);
        check("ch2_fall", fall_obs[2], f + 12);
        check("ch0_rise", rise_obs[0], f + 12);
        check("ch0_fall", fall_obs[0], f + 20);
        check("done_at", done_at, f + 20);
        check("done_once", done_cnt, 1);
        check("ch1_ch3_quiet", rise_cnt[1] + rise_cnt[3], 0);

        // Second edge during a run is dropped.
        clear_obs();
        pulse_trig(2, f);
        pulse_trig(2, f2);
        wait_to(f + 26);
        check("drop_ch0_pulses", rise_cnt[0], 1);
        check("drop_ch2_pulses", rise_cnt[2], 1);
        check("drop_done", done_cnt, 1);

        // Reload ch0=5 mid-run: in-flight pulse keeps old delay.
        clear_obs();
        pulse_trig(1, f);
        load_cfg(5, 0, 1, 0);
        wait_to(f + 24);
        check("inflight_ch0_rise", rise_obs[0], f + 12);
        clear_obs();
        pulse_trig(1, f2);
        wait_to(f2 + 32);
        check("new_ch0_rise", rise_obs[0], f2 + 20);
        check("new_ch0_fall", fall_obs[0], f2 + 28);

        // Maximum delay.
        load_cfg(0, 0, 0, 255);
        clear_obs();
        pulse_trig(1, f);
        wait_to(f + 1032);
        check("ch3_max_rise", rise_obs[3], f + 1020);
        check("ch3_max_fall", fall_obs[3], f + 1028);
        check("ch3_max_done", done_at, f + 1028);

        // Reset while a pulse is high.
        load_cfg(3, 0, 0, 0);
        clear_obs();
        pulse_trig(1, f);
        wait_to(f + 14);
        check("pre_rst_pulse", {31'd0, trig_out[0]}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", {28'd0, trig_out, run, done, cfg_upd}, 32'd0);
        model_clear();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        check("rst_no_done", done_cnt, 0);
        pulse_trig(2, f);
        wait_to(f + 20);
        check("post_rst_rises", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
        check("post_rst_done", done_cnt, 0);

        // Random triggers and config loads, checked every cycle by the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                load_cfg(rand_dly(), rand_dly(), rand_dly(), rand_dly());
            else
                pulse_trig($urandom_range(1, 4), f);
            idle($urandom_range(3, 45));
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
